// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle for pc_sequencer: memory read port, instruction handshake
// to the decoder, and the control/preset lines to the external program counter.
interface pc_sequencer_if #(
    parameter int WIDTH  = 8,
    parameter int IWIDTH = 16
);
    logic [WIDTH-1:0]  pc;
    logic [IWIDTH-1:0] mem_data;
    logic              mem_ready;
    logic              instr_ready;
    logic              jump_req;
    logic [WIDTH-1:0]  jump_addr;
    logic              mem_rd;
    logic [WIDTH-1:0]  fetch_addr;
    logic [IWIDTH-1:0] instr;
    logic              instr_valid;
    logic              pc_inc;
    logic              pc_load;
    logic [WIDTH-1:0]  pc_preset;

    modport master (
        input  pc, mem_data, mem_ready, instr_ready, jump_req, jump_addr,
        output mem_rd, fetch_addr, instr, instr_valid, pc_inc, pc_load, pc_preset
    );

    modport slave (
        output pc, mem_data, mem_ready, instr_ready, jump_req, jump_addr,
        input  mem_rd, fetch_addr, instr, instr_valid, pc_inc, pc_load, pc_preset
    );
endinterface

// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: reads memory at the current pc, holds the word
// for the decoder, then pulses the external counter to increment or jump.
module pc_sequencer #(
    parameter int WIDTH   = 8,
    parameter int IWIDTH  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           run_i,
    output logic           fault_o,
    pc_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, ADVANCE} state_t;

    localparam int             CW        = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  WAIT_LAST = CW'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  fetch_addr_q, fetch_addr_d;
    logic [IWIDTH-1:0] instr_q, instr_d;
    logic              instr_valid_q, instr_valid_d;
    logic              mem_rd_q, mem_rd_d;
    logic              pc_inc_q, pc_inc_d;
    logic              jump_pending_q, jump_pending_d;
    logic [WIDTH-1:0]  pc_preset_q, pc_preset_d;
    logic              fault_q, fault_d;
    logic [CW-1:0]     wait_q, wait_d;
    logic              settle_q, settle_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        fetch_addr_d   = fetch_addr_q;
        instr_d        = instr_q;
        instr_valid_d  = instr_valid_q;
        mem_rd_d       = mem_rd_q;
        pc_inc_d       = 1'b0;
        jump_pending_d = jump_pending_q;
        pc_preset_d    = pc_preset_q;
        fault_d        = fault_q;
        wait_d         = wait_q;
        settle_d       = settle_q;
        case (state_q)
            IDLE: begin
                if (run_i && !fault_q) begin
                    state_d      = FETCH;
                    fetch_addr_d = bus.pc;
                    wait_d       = '0;
                    mem_rd_d     = 1'b1;
                    settle_d     = 1'b0;
                end
            end
            FETCH: begin
                // After an advance the counter has only just moved; give pc a
                // cycle to settle before sampling it and starting the read.
                if (settle_q) begin
                    settle_d     = 1'b0;
                    fetch_addr_d = bus.pc;
                    mem_rd_d     = 1'b1;
                    wait_d       = '0;
                end else if (bus.mem_ready) begin
                    instr_d       = bus.mem_data;
                    instr_valid_d = 1'b1;
                    mem_rd_d      = 1'b0;
                    state_d       = HOLD;
                end else if (wait_q == WAIT_LAST) begin
                    fault_d  = 1'b1;
                    mem_rd_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            HOLD: begin
                if (bus.instr_ready) begin
                    instr_valid_d  = 1'b0;
                    jump_pending_d = bus.jump_req;
                    pc_inc_d       = ~bus.jump_req;
                    if (bus.jump_req) pc_preset_d = bus.jump_addr;
                    state_d = ADVANCE;
                end
            end
            ADVANCE: begin
                jump_pending_d = 1'b0;
                if (run_i) begin
                    state_d  = FETCH;
                    settle_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fetch_addr_q   <= '0;
            instr_q        <= '0;
            instr_valid_q  <= 1'b0;
            mem_rd_q       <= 1'b0;
            pc_inc_q       <= 1'b0;
            jump_pending_q <= 1'b0;
            pc_preset_q    <= '0;
            fault_q        <= 1'b0;
            wait_q         <= '0;
            settle_q       <= 1'b0;
        end else begin
            fetch_addr_q   <= fetch_addr_d;
            instr_q        <= instr_d;
            instr_valid_q  <= instr_valid_d;
            mem_rd_q       <= mem_rd_d;
            pc_inc_q       <= pc_inc_d;
            jump_pending_q <= jump_pending_d;
            pc_preset_q    <= pc_preset_d;
            fault_q        <= fault_d;
            wait_q         <= wait_d;
            settle_q       <= settle_d;
        end
    end

    // The pending-jump flag is high exactly during ADVANCE, so it doubles as the load pulse.
    assign bus.pc_load     = jump_pending_q;
    assign bus.pc_inc      = pc_inc_q;
    assign bus.mem_rd      = mem_rd_q;
    assign bus.fetch_addr  = fetch_addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.pc_preset   = pc_preset_q;
    assign fault_o         = fault_q;
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: program counter and address width.
REQ-002 Parameter IWIDTH, default 16: instruction word width.
REQ-003 Parameter TIMEOUT, default 15: maximum number of FETCH cycles to wait for mem_ready.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 run  input  1  level; high enables continuous fetching.
REQ-007 pc  input  WIDTH  current program counter value, from the counter stage output.
REQ-008 mem_data  input  IWIDTH  instruction word from memory.
REQ-009 mem_ready  input  1  memory data is valid this cycle.
REQ-010 instr_ready  input  1  downstream decoder accepts instr this cycle.
REQ-011 jump_req  input  1  qualifies jump_addr; sampled only on the instr handshake cycle.
REQ-012 jump_addr  input  WIDTH  jump target.
REQ-013 mem_rd  output  1  memory read strobe.
REQ-014 fetch_addr  output  WIDTH  registered read address.
REQ-015 instr  output  IWIDTH  registered instruction.
REQ-016 instr_valid  output  1  instr is valid.
REQ-017 pc_inc  output  1  one-cycle increment pulse that drives the counter clk.
REQ-018 pc_load  output  1  one-cycle pulse that drives the counter load.
REQ-019 pc_preset  output  WIDTH  load value for the counter preset.
REQ-020 fault  output  1  sticky memory-timeout flag.

Function
REQ-021 The FSM SHALL have exactly four states: IDLE, FETCH, HOLD and ADVANCE; all outputs SHALL be registered.
REQ-022 IDLE: when run=1 and fault=0, go to FETCH on the next edge, latch fetch_addr<=pc and clear the wait counter; otherwise stay in IDLE.
REQ-023 FETCH: mem_rd SHALL be 1 and the wait counter SHALL increment each cycle.
REQ-024 FETCH exit on mem_ready=1: latch instr<=mem_data, set instr_valid=1, drop mem_rd and go to HOLD.
REQ-025 FETCH timeout: when the wait counter reaches TIMEOUT without mem_ready, set fault=1, drop mem_rd and go to IDLE; instr_valid SHALL stay 0.
REQ-026 mem_ready on the same cycle as the timeout SHALL win: the fetch completes and fault is not set.
REQ-027 HOLD: instr and instr_valid SHALL stay stable until instr_ready=1.
REQ-028 HOLD handshake cycle (instr_ready=1): clear instr_valid, latch jump_pending<=jump_req and pc_preset<=jump_addr if jump_req=1, then go to ADVANCE.
REQ-029 ADVANCE, jump pending: pc_load=1 for exactly one cycle.
REQ-030 ADVANCE, no jump pending: pc_inc=1 for exactly one cycle.
REQ-031 pc_inc and pc_load SHALL never both be 1 in the same cycle.
REQ-032 ADVANCE exit: go to FETCH if run=1, else IDLE; on entry to FETCH, latch fetch_addr<=pc.
REQ-033 The counter updates on the pc_inc/pc_load pulse, so pc is stable one cycle after ADVANCE.
REQ-034 A FETCH entered directly from ADVANCE SHALL insert one settle cycle with mem_rd=0 before asserting mem_rd, and SHALL latch fetch_addr at the end of that settle cycle.
REQ-035 run falling in FETCH or HOLD SHALL NOT abort the instruction; the current instruction completes through ADVANCE, then the FSM goes to IDLE.
REQ-036 pc wrap-around (all ones, then an increment) is owned by the counter; fetch_addr SHALL follow it to 0 with no special case.
REQ-037 fault SHALL hold IDLE regardless of run; only reset clears fault.

Reset
REQ-038 reset=1 SHALL immediately force state to IDLE and set mem_rd, instr_valid, pc_inc, pc_load, fault and jump_pending to 0, and instr, fetch_addr, pc_preset and the wait counter to 0.
REQ-039 reset asserted mid-FETCH or mid-HOLD SHALL discard the in-flight instruction, with no pc_inc or pc_load pulse.
REQ-040 After reset release, the FSM SHALL stay in IDLE until the first edge that samples run=1.

Verification
REQ-041 The bench SHALL cover: pc=0x05, run=1, mem_ready one cycle after mem_rd, mem_data=0xA5A5, instr_ready=1 immediately -> fetch_addr=0x05, instr=0xA5A5, exactly one pc_inc pulse, next fetch_addr=0x06.
REQ-042 The bench SHALL cover: handshake with jump_req=1, jump_addr=0x3C -> one pc_load pulse with pc_preset=0x3C, no pc_inc, next fetch_addr=0x3C.
REQ-043 The bench SHALL cover: mem_ready never asserted -> mem_rd high for TIMEOUT=15 cycles, then fault=1, FSM in IDLE, no pc pulse; run held at 1 -> no further mem_rd until reset.
REQ-044 The bench SHALL cover: instr_ready held 0 for 10 cycles in HOLD -> instr and instr_valid stable for all 10 cycles; no pc_inc or pc_load until the handshake.
REQ-045 The bench SHALL cover: run dropped in the cycle after mem_rd rises -> the instruction completes, one pc_inc, then IDLE with mem_rd=0.
REQ-046 The bench SHALL cover: reset pulsed in HOLD with instr=0x1234 -> all outputs 0 immediately; pc=0xFF with an increment -> next fetch_addr=0x00.
